// File: rtl/conv_dot_engine.sv
// TAPS-long dot-product engine: serial word loading, one MAC per cycle,
// byte-serial full-precision result under a valid/ready handshake.
module conv_dot_engine #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_sel,
  input  logic              signed_mode,
  input  logic              start,
  output logic              busy,
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready
);
  localparam int ACC_W     = 2*DATA_W + $clog2(TAPS);
  localparam int OUT_BYTES = (ACC_W + 7) / 8;
  localparam int RES_W     = 8*OUT_BYTES;
  localparam int PROD_W    = 2*DATA_W;
  localparam int TC_W      = $clog2(TAPS);
  localparam int BC_W      = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] in_reg [TAPS];
  logic [DATA_W-1:0] w_reg  [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [TC_W-1:0]   tap_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic              mode;

  logic [DATA_W-1:0] op_a, op_b;
  logic [PROD_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [RES_W-1:0]  res;
  logic              last_tap, last_byte;

  // Operands are widened per mode first, so one unsigned multiply yields the
  // correct 2*DATA_W-bit product for both signed and unsigned jobs.
  always_comb begin
    op_a = in_reg[tap_cnt];
    op_b = w_reg[tap_cnt];
    if (mode) begin
      a_ext = {{DATA_W{op_a[DATA_W-1]}}, op_a};
      b_ext = {{DATA_W{op_b[DATA_W-1]}}, op_b};
    end else begin
      a_ext = {{DATA_W{1'b0}}, op_a};
      b_ext = {{DATA_W{1'b0}}, op_b};
    end
    prod = a_ext * b_ext;
    if (mode) begin
      prod_ext = ACC_W'($signed(prod));
      res      = RES_W'($signed(acc));
    end else begin
      prod_ext = ACC_W'(prod);
      res      = RES_W'(acc);
    end
    last_tap  = (tap_cnt == TC_W'(TAPS-1));
    last_byte = (byte_cnt == BC_W'(OUT_BYTES-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    dout       = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_tap) state_nx = OUTPUT;
      end
      OUTPUT: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        dout       = res[8*byte_cnt +: 8];
        dout_last  = last_byte;
        if (dout_ready && last_byte) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        in_reg[k] <= '0;
        w_reg[k]  <= '0;
      end
      acc      <= '0;
      tap_cnt  <= '0;
      byte_cnt <= '0;
      mode     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            for (int unsigned k = 0; k < TAPS-1; k++) begin
              if (din_sel) w_reg[k]  <= w_reg[k+1];
              else         in_reg[k] <= in_reg[k+1];
            end
            if (din_sel) w_reg[TAPS-1]  <= din;
            else         in_reg[TAPS-1] <= din;
          end
          if (start) begin
            acc     <= '0;
            tap_cnt <= '0;
            mode    <= signed_mode;
          end
        end
        COMPUTE: begin
          acc     <= acc + prod_ext;
          tap_cnt <= tap_cnt + 1'b1;
          if (last_tap) byte_cnt <= '0;
        end
        OUTPUT: begin
          if (dout_ready) byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
